operand_fetch_stage: RTL

Decode-side operand stage that consumes the asynchronous read ports of the 32x32 register file and produces the ID/EX pipeline register. Resolves RAW hazards with a WB write-through bypass and an EX/MEM forward. Detects stall conditions, and handles flush and downstream hold.

---
 rtl/operand_fetch_stage_if.sv | 56 +++++
 rtl/operand_fetch_stage.sv | 117 +++++++++++
 2 files changed

// File: rtl/operand_fetch_stage_if.sv
// Bundle of IF/ID, register-file, forwarding and ID/EX signals around the operand fetch stage.
// The master drives the decode-side inputs; the slave (the stage) drives the ID/EX outputs.
interface operand_fetch_stage_if #(
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 32,
    parameter int NB_CTRL = 8
) ();
    logic               i_valid;
    logic [NB_ADDR-1:0] i_rs_addr;
    logic [NB_ADDR-1:0] i_rt_addr;
    logic               i_uses_rs;
    logic               i_uses_rt;
    logic [NB_ADDR-1:0] i_rd_addr;
    logic               i_reg_write;
    logic               i_mem_read;
    logic [NB_DATA-1:0] i_imm;
    logic [NB_CTRL-1:0] i_ctrl;
    logic [NB_DATA-1:0] i_rf_data_a;
    logic [NB_DATA-1:0] i_rf_data_b;
    logic               i_exmem_reg_write;
    logic               i_exmem_mem_read;
    logic [NB_ADDR-1:0] i_exmem_waddr;
    logic [NB_DATA-1:0] i_exmem_data;
    logic               i_wb_write_enable;
    logic [NB_ADDR-1:0] i_wb_waddr;
    logic [NB_DATA-1:0] i_wb_data;
    logic               i_flush;
    logic               i_hold;
    logic               o_stall;
    logic               o_valid;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_DATA-1:0] o_imm;
    logic [NB_ADDR-1:0] o_rd_addr;
    logic               o_reg_write;
    logic               o_mem_read;
    logic [NB_CTRL-1:0] o_ctrl;

    modport master (
        output i_valid, i_rs_addr, i_rt_addr, i_uses_rs, i_uses_rt, i_rd_addr,
               i_reg_write, i_mem_read, i_imm, i_ctrl, i_rf_data_a, i_rf_data_b,
               i_exmem_reg_write, i_exmem_mem_read, i_exmem_waddr, i_exmem_data,
               i_wb_write_enable, i_wb_waddr, i_wb_data, i_flush, i_hold,
        input  o_stall, o_valid, o_data_a, o_data_b, o_imm, o_rd_addr,
               o_reg_write, o_mem_read, o_ctrl
    );

    modport slave (
        input  i_valid, i_rs_addr, i_rt_addr, i_uses_rs, i_uses_rt, i_rd_addr,
               i_reg_write, i_mem_read, i_imm, i_ctrl, i_rf_data_a, i_rf_data_b,
               i_exmem_reg_write, i_exmem_mem_read, i_exmem_waddr, i_exmem_data,
               i_wb_write_enable, i_wb_waddr, i_wb_data, i_flush, i_hold,
        output o_stall, o_valid, o_data_a, o_data_b, o_imm, o_rd_addr,
               o_reg_write, o_mem_read, o_ctrl
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode-side operand stage: resolves sources with EX/MEM forward and WB write-through,
// detects load/ID-EX RAW hazards and produces the ID/EX pipeline register.
module operand_fetch_stage #(
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 32,
    parameter int NB_CTRL = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    operand_fetch_stage_if.slave  bus
);

    logic               valid_q,     valid_d;
    logic [NB_DATA-1:0] data_a_q,    data_a_d;
    logic [NB_DATA-1:0] data_b_q,    data_b_d;
    logic [NB_DATA-1:0] imm_q,       imm_d;
    logic [NB_ADDR-1:0] rd_addr_q,   rd_addr_d;
    logic               reg_write_q, reg_write_d;
    logic               mem_read_q,  mem_read_d;
    logic [NB_CTRL-1:0] ctrl_q,      ctrl_d;

    logic [NB_DATA-1:0] res_a;
    logic [NB_DATA-1:0] res_b;
    logic               hz_idex;
    logic               hz_load;
    logic               hazard;

    // Register 0 is hardwired, so it never matches a producer.
    function automatic logic src_match(input logic uses, input logic [NB_ADDR-1:0] src,
                                       input logic [NB_ADDR-1:0] addr);
        return uses && (src != '0) && (src == addr);
    endfunction

    // EX/MEM is younger than WB and therefore wins when both target the same register.
    function automatic logic [NB_DATA-1:0] resolve(input logic uses, input logic [NB_ADDR-1:0] src,
                                                   input logic [NB_DATA-1:0] rf_data);
        if (src == '0)
            return '0;
        if (bus.i_exmem_reg_write && !bus.i_exmem_mem_read && src_match(uses, src, bus.i_exmem_waddr))
            return bus.i_exmem_data;
        if (bus.i_wb_write_enable && src_match(uses, src, bus.i_wb_waddr))
            return bus.i_wb_data;
        return rf_data;
    endfunction

    always_comb begin
        res_a = resolve(bus.i_uses_rs, bus.i_rs_addr, bus.i_rf_data_a);
        res_b = resolve(bus.i_uses_rt, bus.i_rt_addr, bus.i_rf_data_b);

        hz_idex = valid_q && reg_write_q &&
                  (src_match(bus.i_uses_rs, bus.i_rs_addr, rd_addr_q) ||
                   src_match(bus.i_uses_rt, bus.i_rt_addr, rd_addr_q));
        hz_load = bus.i_exmem_reg_write && bus.i_exmem_mem_read &&
                  (src_match(bus.i_uses_rs, bus.i_rs_addr, bus.i_exmem_waddr) ||
                   src_match(bus.i_uses_rt, bus.i_rt_addr, bus.i_exmem_waddr));
        hazard  = bus.i_valid && (hz_idex || hz_load);

        bus.o_stall = !bus.i_flush && (bus.i_hold || hazard);

        valid_d     = valid_q;
        data_a_d    = data_a_q;
        data_b_d    = data_b_q;
        imm_d       = imm_q;
        rd_addr_d   = rd_addr_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        ctrl_d      = ctrl_q;

        // Bubbles clear only the control flags; the data fields simply hold.
        if (bus.i_flush || (!bus.i_hold && hazard)) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else if (!bus.i_hold) begin
            valid_d     = bus.i_valid;
            data_a_d    = res_a;
            data_b_d    = res_b;
            imm_d       = bus.i_imm;
            rd_addr_d   = bus.i_rd_addr;
            reg_write_d = bus.i_valid && bus.i_reg_write;
            mem_read_d  = bus.i_valid && bus.i_mem_read;
            ctrl_d      = bus.i_ctrl;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q     <= 1'b0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            imm_q       <= '0;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            ctrl_q      <= '0;
        end else begin
            valid_q     <= valid_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            imm_q       <= imm_d;
            rd_addr_q   <= rd_addr_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_data_a    = data_a_q;
    assign bus.o_data_b    = data_b_q;
    assign bus.o_imm       = imm_q;
    assign bus.o_rd_addr   = rd_addr_q;
    assign bus.o_reg_write = reg_write_q;
    assign bus.o_mem_read  = mem_read_q;
    assign bus.o_ctrl      = ctrl_q;

endmodule
